// File: rtl/loader_pkg.sv
// Shared definitions for the program loader and the CPU/Memory top level.
//   state_t   : loader FSM states
//   MEM_WORDS : instruction/data memory depth in 16-bit words
//   MEM_AW    : word-address width of that memory
package loader_pkg;

   localparam int MEM_WORDS = 128;
   localparam int MEM_AW    = $clog2(MEM_WORDS);

   typedef enum logic [2:0] {
      IDLE,   // waiting for the word count N
      HI,     // expecting the high byte of a word
      LO,     // expecting the low byte of a word
      CHK,    // expecting the XOR checksum
      RUN,    // image accepted, CPU released
      ERR     // single cycle that flags a bad frame
   } state_t;

endpackage

// File: rtl/program_loader.sv
// Byte-stream boot loader. Receives a framed program image (N, 2*N data bytes
// high-first, XOR checksum) over a valid/ready byte interface, writes it
// word-by-word into memory while holding the CPU stopped, and releases the
// CPU once the checksum matches.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   rx_data/rx_valid    incoming byte and its valid
//   rx_ready            byte is accepted when rx_valid & rx_ready at posedge
//   mem_we/addr/data    registered single-cycle memory write
//   cpu_run             1 = CPU may execute
//   reload              request (honoured in RUN only) to load a new image
//   busy                frame in progress (HI, LO, CHK)
//   load_err            sticky error flag of the last frame
module program_loader
   import loader_pkg::*;
#(
   parameter int DEPTH = MEM_WORDS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   output logic                     mem_we,
   output logic [$clog2(DEPTH)-1:0] mem_addr,
   output logic [15:0]              mem_data,
   output logic                     cpu_run,
   input  logic                     reload,
   output logic                     busy,
   output logic                     load_err
);

   localparam int AW = $clog2(DEPTH);
   // N is compared in 9 bits so DEPTH itself (128) is a legal count.
   localparam logic [8:0] DEPTH_W = 9'(DEPTH);

   state_t          state_q,    state_d;
   logic [7:0]      n_q,        n_d;
   logic [7:0]      idx_q,      idx_d;
   logic [7:0]      hi_q,       hi_d;
   logic [7:0]      csum_q,     csum_d;
   logic            rx_ready_q, rx_ready_d;
   logic            mem_we_q,   mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [15:0]     mem_data_q, mem_data_d;
   logic            cpu_run_q,  cpu_run_d;
   logic            busy_q,     busy_d;
   logic            load_err_q, load_err_d;

   logic            accept;

   assign accept = rx_valid & rx_ready_q;

   always_comb begin
      // NOTE: every signal gets a default here so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d    = state_q;
      n_d        = n_q;
      idx_d      = idx_q;
      hi_d       = hi_q;
      csum_d     = csum_q;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      load_err_d = load_err_q;

      case (state_q)
         IDLE: if (accept) begin
            if (rx_data != 8'd0 && {1'b0, rx_data} <= DEPTH_W) begin
               n_d        = rx_data;
               idx_d      = 8'd0;
               csum_d     = 8'd0;
               load_err_d = 1'b0;
               state_d    = HI;
            end else begin
               state_d    = ERR;
            end
         end
         HI: if (accept) begin
            hi_d    = rx_data;
            csum_d  = csum_q ^ rx_data;
            state_d = LO;
         end
         LO: if (accept) begin
            csum_d     = csum_q ^ rx_data;
            mem_we_d   = 1'b1;
            mem_addr_d = idx_q[AW-1:0];
            mem_data_d = {hi_q, rx_data};
            idx_d      = idx_q + 8'd1;
            state_d    = (idx_q == n_q - 8'd1) ? CHK : HI;
         end
         CHK: if (accept) begin
            state_d = (rx_data == csum_q) ? RUN : ERR;
         end
         RUN: if (reload) begin
            state_d = IDLE;
         end
         ERR: begin
            load_err_d = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      rx_ready_d = (state_d == IDLE) || (state_d == HI) ||
                   (state_d == LO)   || (state_d == CHK);
      busy_d     = (state_d == HI) || (state_d == LO) || (state_d == CHK);
      cpu_run_d  = (state_d == RUN);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         n_q        <= 8'd0;
         idx_q      <= 8'd0;
         hi_q       <= 8'd0;
         csum_q     <= 8'd0;
         rx_ready_q <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= 16'd0;
         cpu_run_q  <= 1'b0;
         busy_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         idx_q      <= idx_d;
         hi_q       <= hi_d;
         csum_q     <= csum_d;
         rx_ready_q <= rx_ready_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         cpu_run_q  <= cpu_run_d;
         busy_q     <= busy_d;
         load_err_q <= load_err_d;
      end
   end

   assign rx_ready = rx_ready_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign cpu_run  = cpu_run_q;
   assign busy     = busy_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a per-cycle vector table for the
// good load, then directed sequences for checksum errors, illegal counts,
// gaps, reload, mid-frame reset and a full-depth image.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        mem_we;
   logic [6:0]  mem_addr;
   logic [15:0] mem_data;
   logic        cpu_run;
   logic        reload;
   logic        busy;
   logic        load_err;

   program_loader #(.DEPTH(128)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .cpu_run  (cpu_run),
      .reload   (reload),
      .busy     (busy),
      .load_err (load_err)
   );

   always #5 clk = ~clk;

   // Memory model and write monitor.
   logic [15:0] tmem [0:127];
   int          wr_cnt     = 0;
   int          double_cnt = 0;
   logic [6:0]  last_addr  = '0;
   logic        prev_we    = 1'b0;

   always @(posedge clk) begin
      if (mem_we) begin
         tmem[mem_addr] <= mem_data;
         wr_cnt         <= wr_cnt + 1;
         last_addr      <= mem_addr;
      end
      if (mem_we && prev_we) double_cnt <= double_cnt + 1;
      prev_we <= mem_we;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a byte after 'gap' idle cycles and hold it until accepted.
   task automatic send(input logic [7:0] b, input int gap);
      bit done;
      for (int g = 0; g < gap; g++) begin
         rx_valid = 1'b0;
         step();
      end
      rx_valid = 1'b1;
      rx_data  = b;
      done     = 1'b0;
      for (int k = 0; k < 50 && !done; k++) begin
         done = rx_ready;
         step();
      end
      rx_valid = 1'b0;
      if (!done) check("send_timeout", {31'd0, done}, 32'd1);
   endtask

   logic [15:0] fw [0:127];

   function automatic logic [7:0] calc_c(input int n);
      logic [7:0] c = 8'd0;
      for (int i = 0; i < n; i++) c = c ^ fw[i][15:8] ^ fw[i][7:0];
      return c;
   endfunction

   task automatic send_frame(input int n, input logic [7:0] c, input int maxgap);
      send(8'(n), $urandom_range(maxgap, 0));
      for (int i = 0; i < n; i++) begin
         send(fw[i][15:8], $urandom_range(maxgap, 0));
         send(fw[i][7:0],  $urandom_range(maxgap, 0));
      end
      send(c, $urandom_range(maxgap, 0));
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      reload   = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic load_good_words();
      fw[0] = 16'hF103;
      fw[1] = 16'hF204;
      fw[2] = 16'h1012;
      fw[3] = 16'h9000;
   endtask

   typedef struct {
      logic        valid;
      logic [7:0]  data;
      logic        rel;
      logic        e_ready;
      logic        e_we;
      logic [6:0]  e_addr;
      logic [15:0] e_data;
      logic        e_run;
      logic        e_busy;
      logic        e_err;
   } vec_t;

   vec_t vecs [13];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int wc0;
      logic [7:0] bad;
      int mis;

      // Good load, one vector per cycle; rows 3 and 11 are idle/refused bytes.
      vecs[0]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 7'h0, 16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 8'hF1, 1'b0, 1'b1, 1'b0, 7'h0, 16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 7'h0, 16'hF103, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 7'h0, 16'hF103, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 8'hF2, 1'b0, 1'b1, 1'b0, 7'h0, 16'hF103, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 7'h1, 16'hF204, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 7'h1, 16'hF204, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 7'h2, 16'h1012, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 8'h90, 1'b0, 1'b1, 1'b0, 7'h2, 16'h1012, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 7'h3, 16'h9000, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 7'h3, 16'h9000, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 7'h3, 16'h9000, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 7'h3, 16'h9000, 1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 128; i++) tmem[i] = 16'h0000;

      // Reset state, sampled while rst_n is still low.
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      reload   = 1'b0;
      step();
      check("reset_outputs", {4'b0, rx_ready, mem_we, mem_addr, mem_data, cpu_run, busy, load_err}, 32'd0);
      rst_n = 1'b1;
      step();
      check("ready_after_reset", {31'd0, rx_ready}, 32'd1);

      // Table-driven good load.
      for (int i = 0; i < 13; i++) begin
         rx_valid = vecs[i].valid;
         rx_data  = vecs[i].data;
         reload   = vecs[i].rel;
         step();
         check($sformatf("vec%0d", i),
               {4'b0, rx_ready, mem_we, mem_addr, mem_data, cpu_run, busy, load_err},
               {4'b0, vecs[i].e_ready, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data,
                vecs[i].e_run, vecs[i].e_busy, vecs[i].e_err});
      end
      rx_valid = 1'b0;
      reload   = 1'b0;
      check("good_mem", {tmem[0], tmem[1]}, 32'hF103F204);
      check("good_mem_hi", {tmem[2], tmem[3]}, 32'h10129000);
      check("good_wr_cnt", wr_cnt, 32'd4);

      // Bad checksum: four writes, one ERR cycle, then IDLE with load_err.
      load_good_words();
      wc0 = wr_cnt;
      send_frame(4, 8'h97, 0);
      check("bad_c_err_cycle", {29'd0, rx_ready, cpu_run, busy}, 32'd0);
      step();
      check("bad_c_after", {28'd0, rx_ready, cpu_run, busy, load_err}, 32'b1001);
      check("bad_c_writes", wr_cnt - wc0, 32'd4);

      // A following good frame clears load_err and releases the CPU.
      send_frame(4, calc_c(4), 0);
      check("good_after_bad", {30'd0, cpu_run, load_err}, 32'b10);
      reload = 1'b1;
      step();
      reload = 1'b0;
      check("reload_drop", {30'd0, cpu_run, rx_ready}, 32'b01);

      // Illegal counts 00 and 81h.
      for (int k = 0; k < 2; k++) begin
         bad = (k == 0) ? 8'h00 : 8'h81;
         wc0 = wr_cnt;
         send(bad, 0);
         check($sformatf("illegal_%h_err", bad), {30'd0, rx_ready, mem_we}, 32'd0);
         step();
         check($sformatf("illegal_%h_idle", bad), {29'd0, rx_ready, load_err, busy}, 32'b110);
         check($sformatf("illegal_%h_nowr", bad), wr_cnt - wc0, 32'd0);
      end

      // Gaps between bytes give the same image.
      do_reset();
      for (int i = 0; i < 128; i++) tmem[i] = 16'h0000;
      load_good_words();
      send_frame(4, calc_c(4), 5);
      check("gap_mem", {tmem[0], tmem[1]}, 32'hF103F204);
      check("gap_mem_hi", {tmem[2], tmem[3]}, 32'h10129000);
      check("gap_run", {30'd0, cpu_run, load_err}, 32'b10);

      // Reload in RUN, then a one-word frame.
      reload = 1'b1;
      step();
      reload = 1'b0;
      check("reload_run_low", {31'd0, cpu_run}, 32'd0);
      send(8'h01, 0);
      send(8'hAB, 0);
      send(8'hCD, 0);
      send(8'h66, 0);
      check("reload_mem0", {16'd0, tmem[0]}, 32'h0000ABCD);
      check("reload_run", {31'd0, cpu_run}, 32'd1);

      // Reset after the third data byte aborts the frame.
      reload = 1'b1;
      step();
      reload = 1'b0;
      wc0 = wr_cnt;
      send(8'h04, 0);
      send(8'hF1, 0);
      send(8'h03, 0);
      send(8'hF2, 0);
      rst_n = 1'b0;
      step();
      check("midreset_outputs", {4'b0, rx_ready, mem_we, mem_addr, mem_data, cpu_run, busy, load_err}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("midreset_writes", wr_cnt - wc0, 32'd1);
      check("midreset_idle", {29'd0, rx_ready, busy, load_err}, 32'b100);

      // Full depth: 128 words, last write at 7F, no wrap.
      for (int i = 0; i < 128; i++) fw[i] = {8'(i) ^ 8'hA5, 8'(i * 7)};
      wc0 = wr_cnt;
      send_frame(128, calc_c(128), 0);
      check("full_writes", wr_cnt - wc0, 32'd128);
      check("full_last_addr", {25'd0, last_addr}, 32'h7F);
      mis = 0;
      for (int i = 0; i < 128; i++) if (tmem[i] !== fw[i]) mis++;
      check("full_mem", mis, 32'd0);
      check("full_run", {30'd0, cpu_run, load_err}, 32'b10);
      check("we_single_cycle", double_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
